bcd_scan_driver: RTL and testbench

BCD_SCAN_DRIVER -- requirements
Module: bcd_scan_driver

---
 rtl/bcd_scan_driver.sv | 89 ++++++++
 tb/tb_bcd_scan_driver.sv | 139 +++++++++++++
 2 files changed

// File: rtl/bcd_scan_driver.sv
// bcd_scan_driver: binary-to-BCD converter (double dabble) feeding a 4-digit multiplexed display scanner
module bcd_scan_driver #(
   parameter int SCAN_DIV = 50000,
   parameter bit BLANK_LZ = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [13:0] value,
   input  logic        load,
   output logic        busy,
   output logic [3:0]  bcd,
   output logic [3:0]  digit_en
);
   typedef enum logic {IDLE, CONV} state_t;
   state_t state, state_n;
   logic [3:0] iter;
   logic [29:0] sr, sr_n;
   logic [15:0] adj, res, dig;
   logic [3:0] d0, d1, d2, d3;
   logic [19:0] cnt;
   logic [1:0] idx, idx_n;
   logic start, err, last, wrap;
   // state register
   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else state <= state_n;
   // next state: a legal load starts a conversion, the 14th iteration ends it
   always_comb
      state_n = state == IDLE ? (start ? CONV : IDLE) : (last ? IDLE : CONV);
   // control strobes decoded from state and inputs
   always_comb begin
      start = state == IDLE && load && value <= 14'd9999;
      err = state == IDLE && load && value > 14'd9999;
      last = state == CONV && iter == 4'd13;
   end
   // one double-dabble step: add 3 to every BCD nibble >= 5, then shift the whole register left
   always_comb begin
      for (int i = 0; i < 4; i++)
         adj[4*i+:4] = sr[14+4*i+:4] >= 4'd5 ? sr[14+4*i+:4] + 4'd3 : sr[14+4*i+:4];
      sr_n = {adj, sr[13:0]} << 1;
   end
   // leading-zero blanking of the finished result; units digit is never blanked
   always_comb begin
      {d3, d2, d1, d0} = sr_n[29:14];
      res[15:12] = BLANK_LZ && d3 == 4'd0 ? 4'hF : d3;
      res[11:8] = BLANK_LZ && {d3, d2} == 8'd0 ? 4'hF : d2;
      res[7:4] = BLANK_LZ && {d3, d2, d1} == 12'd0 ? 4'hF : d1;
      res[3:0] = d0;
   end
   // conversion datapath and registered busy flag
   always_ff @(posedge clk)
      if (rst) begin
         sr <= '0;
         iter <= '0;
         busy <= 1'b0;
      end else begin
         busy <= state_n == CONV;
         if (start) begin
            sr <= {16'd0, value};
            iter <= '0;
         end else if (state == CONV) begin
            sr <= sr_n;
            iter <= last ? 4'd0 : iter + 4'd1;
         end
      end
   // display digit registers: change only on an error load or at the end of a conversion
   always_ff @(posedge clk)
      if (rst) dig <= BLANK_LZ ? 16'hFFF0 : 16'h0000;
      else if (err) dig <= 16'hAAAA;
      else if (last) dig <= res;
   // scan timing: digit index advances each time the divider wraps
   always_comb begin
      wrap = cnt == 20'(SCAN_DIV - 1);
      idx_n = wrap ? idx + 2'd1 : idx;
   end
   // scan outputs: select and digit code are registered together from the same index
   always_ff @(posedge clk)
      if (rst) begin
         cnt <= '0;
         idx <= '0;
         bcd <= 4'd0;
         digit_en <= 4'b1110;
      end else begin
         cnt <= wrap ? 20'd0 : cnt + 20'd1;
         idx <= idx_n;
         bcd <= dig[4*idx_n+:4];
         digit_en <= ~(4'b0001 << idx_n);
      end
endmodule

// File: tb/tb_bcd_scan_driver.sv
// tb_bcd_scan_driver: table, directed and random checks of bcd_scan_driver against a decimal reference model
module tb_bcd_scan_driver;
   localparam int SD = 4;
   logic clk = 0, rst = 1, load = 0;
   logic [13:0] value = 0;
   logic busy1, busy0;
   logic [3:0] bcd1, bcd0, en1, en0;
   int vectors = 0, miscompares = 0;
   int m_cnt, m_idx, m_left, m_val, e1, e0;
   bit m_busy;
   int d1[4], d0[4];
   typedef struct {
      int v;
      logic [15:0] x1;
      logic [15:0] x0;
   } vec_t;
   vec_t tbl[10];

   bcd_scan_driver #(.SCAN_DIV(SD), .BLANK_LZ(1)) dut1 (
      .clk(clk), .rst(rst), .value(value), .load(load),
      .busy(busy1), .bcd(bcd1), .digit_en(en1));
   bcd_scan_driver #(.SCAN_DIV(SD), .BLANK_LZ(0)) dut0 (
      .clk(clk), .rst(rst), .value(value), .load(load),
      .busy(busy0), .bcd(bcd0), .digit_en(en0));

   always #5 clk = ~clk;

   task automatic chk(string n, int a, int e);
      vectors++;
      if (a != e) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at %0t", n, a, e, $time);
      end
   endtask

   // decimal digits of v; blanked copy hides zeros above the leading digit
   function automatic void set_disp(int v);
      int p = 1;
      for (int i = 0; i < 4; i++) begin
         d0[i] = (v / p) % 10;
         d1[i] = (i > 0 && v < p) ? 15 : d0[i];
         p = p * 10;
      end
   endfunction

   task automatic step(bit r, bit l, int v);
      rst = r;
      load = l;
      value = 14'(v);
      @(posedge clk);
      if (r) begin
         m_cnt = 0; m_idx = 0; e1 = 0; e0 = 0; m_busy = 0;
         d1 = '{0, 15, 15, 15};
         d0 = '{0, 0, 0, 0};
      end else begin
         m_cnt = (m_cnt + 1) % SD;
         if (m_cnt == 0) m_idx = (m_idx + 1) % 4;
         e1 = d1[m_idx];
         e0 = d0[m_idx];
         if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
               set_disp(m_val);
               m_busy = 0;
            end
         end else if (l) begin
            if (v > 9999) begin
               d1 = '{10, 10, 10, 10};
               d0 = '{10, 10, 10, 10};
            end else begin
               m_busy = 1; m_left = 14; m_val = v;
            end
         end
      end
      #1;
      chk("busy1", busy1, m_busy);
      chk("busy0", busy0, m_busy);
      chk("bcd1", bcd1, e1);
      chk("bcd0", bcd0, e0);
      chk("en1", en1, 15 & ~(1 << m_idx));
      chk("en0", en0, 15 & ~(1 << m_idx));
   endtask

   // idle long enough to scan every digit, then compare what was shown per position
   task automatic show(string n, logic [15:0] x1, logic [15:0] x0);
      logic [15:0] s1 = 16'h0, s0 = 16'h0;
      repeat (20) begin
         step(0, 0, 0);
         for (int j = 0; j < 4; j++) begin
            if (en1 == 4'(~(1 << j))) s1[4*j+:4] = bcd1;
            if (en0 == 4'(~(1 << j))) s0[4*j+:4] = bcd0;
         end
      end
      chk({n, "_lz1"}, int'(s1), int'(x1));
      chk({n, "_lz0"}, int'(s0), int'(x0));
   endtask

   initial begin
      tbl[0] = '{1234, 16'h1234, 16'h1234};
      tbl[1] = '{7, 16'hFFF7, 16'h0007};
      tbl[2] = '{0, 16'hFFF0, 16'h0000};
      tbl[3] = '{10000, 16'hAAAA, 16'hAAAA};
      tbl[4] = '{9999, 16'h9999, 16'h9999};
      tbl[5] = '{305, 16'hF305, 16'h0305};
      tbl[6] = '{1000, 16'h1000, 16'h1000};
      tbl[7] = '{16383, 16'hAAAA, 16'hAAAA};
      tbl[8] = '{40, 16'hFF40, 16'h0040};
      tbl[9] = '{5090, 16'h5090, 16'h5090};
      step(1, 0, 0);
      step(1, 0, 0);
      show("reset", 16'hFFF0, 16'h0000);
      for (int k = 0; k < 10; k++) begin
         step(0, 1, tbl[k].v);
         repeat (15) step(0, 0, 0);
         show($sformatf("tbl%0d", k), tbl[k].x1, tbl[k].x0);
      end
      step(0, 1, 4321);
      repeat (4) step(0, 0, 0);
      step(0, 1, 55);
      repeat (15) step(0, 0, 0);
      show("drop_load", 16'h4321, 16'h4321);
      step(0, 1, 8888);
      repeat (7) step(0, 0, 0);
      step(1, 0, 0);
      show("abort", 16'hFFF0, 16'h0000);
      step(0, 1, 8888);
      repeat (15) step(0, 0, 0);
      show("reload", 16'h8888, 16'h8888);
      step(1, 1, 1234);
      show("rst_load", 16'hFFF0, 16'h0000);
      repeat (600) begin
         int v;
         v = $urandom_range(0, 2) == 0 ? int'($urandom_range(0, 99)) : int'($urandom_range(0, 16383));
         step($urandom_range(0, 149) == 0, $urandom_range(0, 3) == 0, v);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
